blake2s_block_fmt: RTL

Upstream formatting stage for blake2s_hash256. It takes a host byte stream (optional key bytes followed by message bytes) and turns it into the core's 64-byte block stream, with in-block index, block_first/block_last flags and BLAKE2s zero padding. It sits between the host I/O interface and the hash core, and applies core backpressure to the host.

---
 rtl/blake2s_pkg.sv | 34 +++
 rtl/blake2s_block_fmt_if.sv | 35 +++
 rtl/blake2s_block_fmt.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/blake2s_pkg.sv
// Shared constants, FSM state encoding and block-count helpers for the BLAKE2s
// block formatter.
package blake2s_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int IDX_W       = 6;
  localparam int KK_MAX      = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEY     = 3'd1,
    KEY_PAD = 3'd2,
    MSG     = 3'd3,
    MSG_PAD = 3'd4,
    FIN     = 3'd5
  } state_e;

  // ceil(ll / 64): message blocks needed for ll bytes
  function automatic logic [63:0] ll_blocks(input logic [63:0] ll);
    return {6'd0, ll[63:6]} + {63'd0, |ll[5:0]};
  endfunction

  // An empty key and an empty message still hash one all-zero block
  function automatic logic [63:0] total_blocks(input logic [5:0] kk, input logic [63:0] ll);
    logic [63:0] n;
    if ((kk == 6'd0) && (ll == 64'd0)) begin
      n = 64'd1;
    end else begin
      n = ll_blocks(ll) + ((kk != 6'd0) ? 64'd1 : 64'd0);
    end
    return n;
  endfunction

endpackage

// File: rtl/blake2s_block_fmt_if.sv
// Host-side and core-side signal bundle of the BLAKE2s block formatter.
interface blake2s_block_fmt_if
  import blake2s_pkg::*;
#(
  parameter int LL_W = 64
) ();

  logic             cfg_v_i;
  logic [7:0]       kk_i;
  logic [LL_W-1:0]  ll_i;
  logic             byte_v_i;
  logic [7:0]       byte_i;
  logic             byte_ready_o;
  logic             core_ready_i;
  logic             data_v_o;
  logic [7:0]       data_o;
  logic [IDX_W-1:0] data_idx_o;
  logic             block_first_o;
  logic             block_last_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output cfg_v_i, kk_i, ll_i, byte_v_i, byte_i, core_ready_i,
    input  byte_ready_o, data_v_o, data_o, data_idx_o,
           block_first_o, block_last_o, busy_o, done_o
  );

  modport slave (
    input  cfg_v_i, kk_i, ll_i, byte_v_i, byte_i, core_ready_i,
    output byte_ready_o, data_v_o, data_o, data_idx_o,
           block_first_o, block_last_o, busy_o, done_o
  );

endinterface

// File: rtl/blake2s_block_fmt.sv
// Turns a host key+message byte stream into zero-padded 64-byte BLAKE2s blocks
// with in-block index and first/last block flags; core backpressure stalls the host.
module blake2s_block_fmt
  import blake2s_pkg::*;
#(
  parameter int BLOCK_BYTES = 64,
  parameter int LL_W        = 64
) (
  input logic               clk,
  input logic               nreset,
  blake2s_block_fmt_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [LL_W-1:0]  LL_ONE   = {{(LL_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [5:0]       kk_cnt_r;
  logic [LL_W-1:0]  rem_r;
  logic [63:0]      blk_left_r;
  logic             first_r;

  logic             data_v_r;
  logic [7:0]       data_r;
  logic [IDX_W-1:0] data_idx_r;
  logic             block_first_r;
  logic             block_last_r;
  logic             busy_r;
  logic             done_r;

  logic             take_s;
  logic             accept_s;
  logic             pad_step_s;
  logic             blk_end_s;
  logic [5:0]       kk_clamp_s;
  logic [63:0]      ll_ext_s;

  // Handshake qualifiers and configuration decode
  always_comb begin
    take_s     = 1'b0;
    pad_step_s = 1'b0;
    if (bus.core_ready_i && ((state_r == KEY) || (state_r == MSG))) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    if (bus.core_ready_i && ((state_r == KEY_PAD) || (state_r == MSG_PAD))) begin
      pad_step_s = 1'b1;
    end else begin
      pad_step_s = 1'b0;
    end
    accept_s  = take_s && bus.byte_v_i;
    blk_end_s = (idx_r == LAST_IDX);
    if (bus.kk_i > 8'(KK_MAX)) begin
      kk_clamp_s = 6'(KK_MAX);
    end else begin
      kk_clamp_s = bus.kk_i[5:0];
    end
    ll_ext_s = 64'(bus.ll_i);
  end

  // Formatter FSM, block counters and registered core-side outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      kk_cnt_r      <= 6'd0;
      rem_r         <= '0;
      blk_left_r    <= 64'd0;
      first_r       <= 1'b0;
      data_v_r      <= 1'b0;
      data_r        <= 8'h00;
      data_idx_r    <= '0;
      block_first_r <= 1'b0;
      block_last_r  <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      data_v_r <= 1'b0;
      done_r   <= 1'b0;

      // Data and pad bytes share one emit path so flags and index stay aligned
      if (accept_s || pad_step_s) begin
        data_v_r      <= 1'b1;
        data_r        <= accept_s ? bus.byte_i : 8'h00;
        data_idx_r    <= idx_r;
        block_first_r <= first_r;
        block_last_r  <= (blk_left_r == 64'd1);
        idx_r         <= idx_r + 6'd1;
        if (blk_end_s) begin
          first_r    <= 1'b0;
          blk_left_r <= blk_left_r - 64'd1;
        end
      end

      case (state_r)
        IDLE: begin
          if (bus.cfg_v_i) begin
            kk_cnt_r   <= kk_clamp_s;
            rem_r      <= bus.ll_i;
            blk_left_r <= total_blocks(kk_clamp_s, ll_ext_s);
            idx_r      <= '0;
            first_r    <= 1'b1;
            busy_r     <= 1'b1;
            if (kk_clamp_s != 6'd0) begin
              state_r <= KEY;
            end else if (bus.ll_i != '0) begin
              state_r <= MSG;
            end else begin
              state_r <= MSG_PAD;
            end
          end
        end
        KEY: begin
          if (accept_s) begin
            kk_cnt_r <= kk_cnt_r - 6'd1;
            if (kk_cnt_r == 6'd1) begin
              state_r <= KEY_PAD;
            end
          end
        end
        KEY_PAD: begin
          if (pad_step_s && blk_end_s) begin
            state_r <= (rem_r != '0) ? MSG : FIN;
          end
        end
        MSG: begin
          if (accept_s) begin
            rem_r <= rem_r - LL_ONE;
            if (rem_r == LL_ONE) begin
              state_r <= blk_end_s ? FIN : MSG_PAD;
            end
          end
        end
        MSG_PAD: begin
          if (pad_step_s && blk_end_s) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready_o  = take_s;
  assign bus.data_v_o      = data_v_r;
  assign bus.data_o        = data_r;
  assign bus.data_idx_o    = data_idx_r;
  assign bus.block_first_o = block_first_r;
  assign bus.block_last_o  = block_last_r;
  assign bus.busy_o        = busy_r;
  assign bus.done_o        = done_r;

endmodule
